// File: rtl/fixed.sv
// Fixed-point Q16.15 type and constants shared by the inverse-sqrt datapath.
package fixed_pkg;
  typedef logic signed [31:0] fixed_t;
  localparam int FIXED_FRAC = 15;
  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
endpackage

// File: rtl/inv_sqrt_arb_pkg.sv
// Shared types and helpers for inv_sqrt_arbiter.
// Optional feature macro: INV_SQRT_ARB_NONPOS_FLAG_EN adds the err tag bit.
package inv_sqrt_arb_pkg;
  localparam int LATENCY = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
`ifdef INV_SQRT_ARB_NONPOS_FLAG_EN
    logic       err;
`endif
  } arb_tag_t;

  // Round-robin pick over the first n bits of mask, searching from ptr upward
  // with wrap. Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [3:0] idx;
    logic       found;
    logic [2:0] pick;
    found = 1'b0;
    pick  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && mask[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
    return {found, pick};
  endfunction
endpackage

// File: rtl/fixed_inv_sqrt.sv
// Four-stage Q16.15 reciprocal square root, no reset on the datapath.
// y = sqrt(2^45 / x) (integer floor), which is 1/sqrt(x) in Q16.15.
// Non-positive operands produce FIXED_MAX.
module fixed_inv_sqrt
  import fixed_pkg::*;
(
  input  logic   clk,
  input  fixed_t x,
  output fixed_t y
);
  localparam logic [45:0] NUMER = 46'd1 << (3 * FIXED_FRAC);

  fixed_t      x_q;
  logic [45:0] quo_q;
  logic [22:0] root_q;
  logic        nonpos_q1;
  logic        nonpos_q2;

  // Digit-by-digit integer square root, unrolled.
  function automatic logic [22:0] isqrt46(input logic [45:0] v);
    logic [22:0] r;
    logic [22:0] c;
    logic [45:0] sq;
    r = '0;
    for (int b = 22; b >= 0; b--) begin
      c  = r | (23'd1 << b);
      sq = {23'd0, c} * {23'd0, c};
      if (sq <= v) r = c;
    end
    return r;
  endfunction

  // Register operand, divide, root, then format the result.
  always_ff @(posedge clk) begin
    x_q       <= x;
    nonpos_q1 <= (x_q <= 0);
    quo_q     <= (x_q > 0) ? (NUMER / {15'd0, x_q[30:0]}) : '0;
    nonpos_q2 <= nonpos_q1;
    root_q    <= isqrt46(quo_q);
    y         <= nonpos_q2 ? FIXED_MAX : fixed_t'({9'd0, root_q});
  end
endmodule

// File: rtl/inv_sqrt_arbiter_rr_grant.sv
// Round-robin grant: mask + pointer in, one-hot grant and index out.
module rr_grant
  import inv_sqrt_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       idx,
  output logic             any
);
  logic [7:0] mask_ext;
  logic [3:0] pick;

  // Widen the mask for the shared picker and decode its result to one-hot.
  always_comb begin
    mask_ext             = '0;
    mask_ext[N_REQ-1:0]  = mask;
    pick                 = rr_pick(mask_ext, ptr, 4'(N_REQ));
    any                  = pick[3];
    idx                  = pick[2:0];
    grant                = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (any && (pick[2:0] == 3'(i))) grant[i] = 1'b1;
    end
  end
endmodule

// File: rtl/inv_sqrt_arbiter.sv
// Shares one fixed_inv_sqrt pipe among N_REQ requesters, round-robin, with a
// per-requester cap on in-flight operations and tagged result routing.
// Optional feature macro: INV_SQRT_ARB_NONPOS_FLAG_EN flags operands <= 0 on
// resp_err_out and zeroes their result.
module inv_sqrt_arbiter
  import inv_sqrt_arb_pkg::*;
  import fixed_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [N_REQ-1:0]      req_valid_in,
  input  logic [N_REQ-1:0][31:0] req_data_in,
  output logic [N_REQ-1:0]      req_ready_out,
  output logic [N_REQ-1:0]      resp_valid_out,
  output logic [31:0]           resp_data_out
`ifdef INV_SQRT_ARB_NONPOS_FLAG_EN
  , output logic                resp_err_out
`endif
);
  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  logic [2:0]       ptr;
  logic [2:0]       out_cnt [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] retire;
  logic [2:0]       grant_idx;
  logic             grant_any;
  fixed_t           pipe_in;
  fixed_t           pipe_out;
  arb_tag_t         tag_in;
  arb_tag_t         tag_pipe [LATENCY];

  // A requester competes only while valid, under its cap, and out of reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = rst_n_in && req_valid_in[i] && (out_cnt[i] < MAX_OUT_C);
    end
  end

  rr_grant #(.N_REQ(N_REQ)) u_grant (
    .mask  (eligible),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready_out = grant;

  // Steer the granted operand into the pipe and build its tag.
  always_comb begin
    pipe_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) pipe_in = req_data_in[i];
    end
    tag_in       = '0;
    tag_in.valid = grant_any;
    tag_in.id    = grant_idx;
`ifdef INV_SQRT_ARB_NONPOS_FLAG_EN
    tag_in.err   = grant_any && (pipe_in[31] || (pipe_in == '0));
`endif
  end

  fixed_inv_sqrt u_pipe (
    .clk (clk_in),
    .x   (pipe_in),
    .y   (pipe_out)
  );

  // The tag leaving the last stage retires its requester's operation.
  always_comb begin
    retire = '0;
    for (int i = 0; i < N_REQ; i++) begin
      retire[i] = tag_pipe[LATENCY-1].valid && (tag_pipe[LATENCY-1].id == 3'(i));
    end
  end

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ptr <= '0;
    else if (grant_any) ptr <= (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  // Tag shift register tracks the pipe; clearing it drops in-flight results.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Outstanding counters: up on accept, down on response, net zero on both.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_REQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !retire[i]) begin
          assert (out_cnt[i] < MAX_OUT_C);
          out_cnt[i] <= out_cnt[i] + 3'd1;
        end else if (retire[i] && !grant[i]) begin
          assert (out_cnt[i] != 3'd0);
          out_cnt[i] <= out_cnt[i] - 3'd1;
        end
      end
    end
  end

  // Registered response, aligned with the pipe output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resp_valid_out <= '0;
      resp_data_out  <= '0;
`ifdef INV_SQRT_ARB_NONPOS_FLAG_EN
      resp_err_out   <= 1'b0;
`endif
    end else begin
      resp_valid_out <= retire;
`ifdef INV_SQRT_ARB_NONPOS_FLAG_EN
      resp_err_out   <= tag_pipe[LATENCY-1].valid && tag_pipe[LATENCY-1].err;
      if (tag_pipe[LATENCY-1].valid)
        resp_data_out <= tag_pipe[LATENCY-1].err ? 32'd0 : pipe_out;
`else
      if (tag_pipe[LATENCY-1].valid) resp_data_out <= pipe_out;
`endif
    end
  end
endmodule
